// File: rtl/lsu_pkg.sv
//----------------------------------------------------------------------------
// Module      : lsu_pkg
// Description : Shared size codes, FSM encodings and legality helper for the
//               RISC-V load-store unit.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    // funct3 size codes
    localparam logic [2:0] c_SZ_B  = 3'b000;
    localparam logic [2:0] c_SZ_H  = 3'b001;
    localparam logic [2:0] c_SZ_W  = 3'b010;
    localparam logic [2:0] c_SZ_BU = 3'b100;
    localparam logic [2:0] c_SZ_HU = 3'b101;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    localparam int c_WDOG_W = 16;

    // Unsigned sizes have no store form; H/W must be naturally aligned.
    function automatic logic lsu_legal(input logic       we,
                                       input logic [2:0] size,
                                       input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (size)
            c_SZ_B:  ok = 1'b1;
            c_SZ_BU: ok = !we;
            c_SZ_H:  ok = !offset[0];
            c_SZ_HU: ok = !we && !offset[0];
            c_SZ_W:  ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
//----------------------------------------------------------------------------
// Module      : lsu_load_align
// Description : Shifts a memory word down to the addressed byte lane and
//               sign/zero-extends it according to the load size.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_word >> {i_offset, 3'b000};
        case (i_size)
            c_SZ_B:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_BU: o_data = {24'h000000, w_shifted[7:0]};
            c_SZ_H:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_SZ_HU: o_data = {16'h0000, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu.sv
//----------------------------------------------------------------------------
// Module      : riscv_lsu
// Description : Load-store unit between the core data port and a req/ready
//               data memory; stalls the core, formats data, flags faults.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module riscv_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              lsu_fault_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
);

    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);
    localparam bit                  c_WDOG_EN   = (TIMEOUT != 0);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_we;
    logic [2:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wd;
    logic [31:0]         r_rd;
    logic [c_WDOG_W-1:0] r_wdog;

    logic                w_legal;
    logic                w_start;
    logic                w_timeout;
    logic                w_access;
    logic [3:0]          w_be;
    logic [31:0]         w_wd;
    logic [31:0]         w_load_data;

    // Request decode; size[1:0] selects lane width for both signed and unsigned codes
    always_comb begin
        w_legal = lsu_legal(core_we_i, core_size_i, core_addr_i[1:0]);
        case (core_size_i[1:0])
            2'b00: begin
                w_be = 4'b0001 << core_addr_i[1:0];
                w_wd = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                w_be = 4'b0011 << {core_addr_i[1], 1'b0};
                w_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = core_wd_i;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (core_req_i && w_legal) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (mem_ready_i) begin
                    w_state_nxt = c_ST_RESP;
                end else if (c_WDOG_EN && (r_wdog == c_WDOG_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .i_word   (mem_rd_i),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wd    <= 32'h0;
            r_rd    <= 32'h0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_we   <= core_we_i;
                r_size <= core_size_i;
                r_addr <= core_addr_i;
                r_be   <= w_be;
                r_wd   <= w_wd;
                r_wdog <= '0;
            end else if (w_access) begin
                r_wdog <= r_wdog + c_WDOG_ONE;
            end
            if (w_access && mem_ready_i && !r_we) begin
                r_rd <= w_load_data;
            end
        end
    end

    assign w_access = (r_state == c_ST_ACCESS);

    // rst_i gating keeps combinational outputs quiet while the core is held in reset
    assign core_stall_o = rst_i && (w_start || w_access);
    assign lsu_fault_o  = rst_i && (((r_state == c_ST_IDLE) && core_req_i && !w_legal) || w_timeout);

    assign core_rd_o  = r_rd;
    assign mem_req_o  = w_access;
    assign mem_we_o   = w_access && r_we;
    assign mem_be_o   = w_access ? r_be : 4'b0000;
    assign mem_addr_o = w_access ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wd_o   = w_access ? r_wd : 32'h0;

endmodule

`default_nettype wire
